// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and default widths for the serial-audio clock
//               generator.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Frame formats; the unused encoding 2'd3 is decoded as I2S.
    typedef enum logic [1:0] {
        FMT_I2S = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_DSP = 2'd2
    } fmt_e;

    localparam int c_div_w_def = 8;
    localparam int c_sb_w_def  = 6;
    localparam int c_sl_w_def  = 4;

endpackage
`default_nettype wire

// File: rtl/i2s_sclk_div.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sclk_div
// Description : Bit-clock divider. Counts 0..div-1 and toggles sclk on the
//               terminal count. The rise/fall outputs flag, combinationally,
//               that the toggle happens at the coming clock edge so the caller
//               can register its own state in the same cycle as sclk.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_sclk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_sclk,
    output logic             o_rise,
    output logic             o_fall
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_tc;

    // i_div is already clamped to at least 1 by the caller
    assign w_tc   = i_en && (r_cnt == (i_div - DIV_W'(1)));
    assign o_rise = w_tc && !r_sclk;
    assign o_fall = w_tc && r_sclk;
    assign o_sclk = r_sclk;

    // Half-period counter and sclk toggle; disabled means parked low at zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tc) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_tdm_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tdm_clk_gen
// Description : Runtime-configurable I2S / left-justified / DSP-TDM bit clock
//               and frame sync generator with bit/slot position outputs and
//               transmit/receive edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tdm_clk_gen
    import i2s_pkg::*;
#(
    parameter int DIV_W = c_div_w_def,
    parameter int SB_W  = c_sb_w_def,
    parameter int SL_W  = c_sl_w_def,
    parameter int POS_W = SB_W + SL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [SB_W-1:0]  cfg_slot_bits,
    input  logic [SL_W-1:0]  cfg_slots,
    input  logic [1:0]       cfg_fmt,
    output logic             sclk,
    output logic             fsync,
    output logic             bit_strobe,
    output logic             sample_strobe,
    output logic             frame_start,
    output logic [SL_W-1:0]  slot_idx,
    output logic [SB_W-1:0]  bit_idx,
    output logic             active
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_run      = 2'd1;
    localparam logic [1:0] c_st_stopping = 2'd2;

    logic [1:0]       r_state;
    logic             r_active;
    logic             r_fsync;
    logic             r_bit_strobe;
    logic             r_sample_strobe;
    logic             r_frame_start;
    logic [POS_W-1:0] r_pos;
    logic [SL_W-1:0]  r_slot;
    logic [SB_W-1:0]  r_bit;

    // Frame configuration, captured only at start-up and at frame wraps
    logic [DIV_W-1:0] r_div;
    logic [SB_W-1:0]  r_sb;
    logic [SL_W-1:0]  r_sl;
    logic [1:0]       r_fmt;
    logic [POS_W-1:0] r_f;
    logic [POS_W-1:0] r_h;

    logic [DIV_W-1:0] w_div_clamp;
    logic [SB_W-1:0]  w_sb_clamp;
    logic [SL_W-1:0]  w_sl_clamp;
    logic [POS_W-1:0] w_f_new;
    logic [POS_W-1:0] w_h_new;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_sclk;

    assign w_div_clamp = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    assign w_sb_clamp  = (cfg_slot_bits < SB_W'(2)) ? SB_W'(2) : cfg_slot_bits;
    assign w_sl_clamp  = (cfg_slots == '0) ? SL_W'(1) : cfg_slots;
    assign w_f_new     = POS_W'(w_sl_clamp) * POS_W'(w_sb_clamp);
    assign w_h_new     = w_f_new >> 1;
    assign w_pos_nxt   = r_pos + POS_W'(1);

    // Frame-sync level for a given position; I2S leads the frame by one bit
    function automatic logic fsync_calc(input logic [1:0]       fmt,
                                        input logic [POS_W-1:0] p,
                                        input logic [POS_W-1:0] f,
                                        input logic [POS_W-1:0] h);
        logic w_res;
        case (fmt_e'(fmt))
            FMT_LJ:  w_res = (p <= (h - POS_W'(1)));
            FMT_DSP: w_res = (p == (f - POS_W'(1)));
            default: w_res = (p >= (h - POS_W'(1))) && (p <= (f - POS_W'(2)));
        endcase
        return w_res;
    endfunction

    i2s_sclk_div #(
        .DIV_W (DIV_W)
    ) u_sclk_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_active),
        .i_div  (r_div),
        .o_sclk (w_sclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // Run/stop FSM with position counters, fsync decode and edge strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state         <= c_st_idle;
            r_active        <= 1'b0;
            r_fsync         <= 1'b0;
            r_bit_strobe    <= 1'b0;
            r_sample_strobe <= 1'b0;
            r_frame_start   <= 1'b0;
            r_pos           <= '0;
            r_slot          <= '0;
            r_bit           <= '0;
            r_div           <= DIV_W'(1);
            r_sb            <= SB_W'(2);
            r_sl            <= SL_W'(1);
            r_fmt           <= 2'd0;
            r_f             <= POS_W'(2);
            r_h             <= POS_W'(1);
        end else begin
            r_bit_strobe    <= 1'b0;
            r_sample_strobe <= 1'b0;
            r_frame_start   <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (en) begin
                        r_div    <= w_div_clamp;
                        r_sb     <= w_sb_clamp;
                        r_sl     <= w_sl_clamp;
                        r_fmt    <= cfg_fmt;
                        r_f      <= w_f_new;
                        r_h      <= w_h_new;
                        r_active <= 1'b1;
                        r_pos    <= '0;
                        r_slot   <= '0;
                        r_bit    <= '0;
                        r_fsync  <= fsync_calc(cfg_fmt, '0, w_f_new, w_h_new);
                        r_state  <= c_st_run;
                    end
                end
                c_st_run, c_st_stopping: begin
                    r_sample_strobe <= w_rise;
                    r_state         <= en ? c_st_run : c_st_stopping;
                    if (w_fall) begin
                        r_bit_strobe <= 1'b1;
                        if (r_pos == (r_f - POS_W'(1))) begin
                            // Frame wrap: either stop cleanly or re-latch config
                            r_frame_start <= 1'b1;
                            r_pos         <= '0;
                            r_slot        <= '0;
                            r_bit         <= '0;
                            if (!en) begin
                                r_active <= 1'b0;
                                r_fsync  <= 1'b0;
                                r_state  <= c_st_idle;
                            end else begin
                                r_div   <= w_div_clamp;
                                r_sb    <= w_sb_clamp;
                                r_sl    <= w_sl_clamp;
                                r_fmt   <= cfg_fmt;
                                r_f     <= w_f_new;
                                r_h     <= w_h_new;
                                r_fsync <= fsync_calc(cfg_fmt, '0, w_f_new, w_h_new);
                            end
                        end else begin
                            r_pos   <= w_pos_nxt;
                            r_fsync <= fsync_calc(r_fmt, w_pos_nxt, r_f, r_h);
                            if (r_bit == (r_sb - SB_W'(1))) begin
                                r_bit  <= '0;
                                r_slot <= (r_slot == (r_sl - SL_W'(1))) ? '0 : r_slot + SL_W'(1);
                            end else begin
                                r_bit  <= r_bit + SB_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign sclk          = w_sclk;
    assign fsync         = r_fsync;
    assign bit_strobe    = r_bit_strobe;
    assign sample_strobe = r_sample_strobe;
    assign frame_start   = r_frame_start;
    assign slot_idx      = r_slot;
    assign bit_idx       = r_bit;
    assign active        = r_active;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_tdm_clk_gen
// Description : Scoreboard bench for i2s_tdm_clk_gen. Each scenario queues
//               the expected state at every transmit edge; a monitor pops
//               and compares whenever bit_strobe is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tdm_clk_gen;

    localparam int DIV_W = 8;
    localparam int SB_W  = 6;
    localparam int SL_W  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [SB_W-1:0]  cfg_slot_bits = '0;
    logic [SL_W-1:0]  cfg_slots = '0;
    logic [1:0]       cfg_fmt = '0;
    logic             sclk, fsync, bit_strobe, sample_strobe, frame_start, active;
    logic [SL_W-1:0]  slot_idx;
    logic [SB_W-1:0]  bit_idx;

    typedef struct {
        logic            fs;
        logic            fsy;
        logic [SL_W-1:0] slot;
        logic [SB_W-1:0] bitn;
        logic            act;
        int              gap;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_err = 0, n_pop = 0, cyc = 0, last_fall = 0, last_rise = 0;
    bit   sb_on = 1'b0;

    i2s_tdm_clk_gen dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_div       (cfg_div),
        .cfg_slot_bits (cfg_slot_bits),
        .cfg_slots     (cfg_slots),
        .cfg_fmt       (cfg_fmt),
        .sclk          (sclk),
        .fsync         (fsync),
        .bit_strobe    (bit_strobe),
        .sample_strobe (sample_strobe),
        .frame_start   (frame_start),
        .slot_idx      (slot_idx),
        .bit_idx       (bit_idx),
        .active        (active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic exp_fsync(input int fmt, input int p, input int f, input int h);
        if (fmt == 1) return (p <= h - 1);
        if (fmt == 2) return (p == f - 1);
        return (p >= h - 1) && (p <= f - 2);
    endfunction

    // Monitor: compare the queued expectation at every transmit edge
    always @(negedge clk) begin : mon
        exp_t e;
        int   gap, half;
        if (sb_on && rst) begin
            if (sample_strobe) begin
                n_cmp++;
                if (sclk !== 1'b1) begin
                    n_err++;
                    $display("FAIL sample_edge: sclk=%0b at sample_strobe, want 1", sclk);
                end
                last_rise = cyc;
            end
            if (bit_strobe) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL bit_event: unexpected bit_strobe at cycle %0d, want none", cyc);
                end else begin
                    e    = q.pop_front();
                    gap  = cyc - last_fall;
                    half = cyc - last_rise;
                    if (frame_start !== e.fs || fsync !== e.fsy || slot_idx !== e.slot ||
                        bit_idx !== e.bitn || active !== e.act || sclk !== 1'b0 ||
                        (e.gap != 0 && (gap != e.gap || half != e.gap / 2))) begin
                        n_err++;
                        $display("FAIL bit_event %0d: got fs=%0b fsync=%0b slot=%0d bit=%0d act=%0b sclk=%0b gap=%0d half=%0d; want fs=%0b fsync=%0b slot=%0d bit=%0d act=%0b sclk=0 gap=%0d half=%0d",
                                 n_pop, frame_start, fsync, slot_idx, bit_idx, active, sclk, gap, half,
                                 e.fs, e.fsy, e.slot, e.bitn, e.act, e.gap, e.gap / 2);
                    end
                end
                last_fall = cyc;
                n_pop++;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Queue every transmit-edge expectation for nfr frames ending in a stop
    task automatic push_run(input int fmt, input int sb, input int sl,
                            input int d0, input int d1, input int nfr);
        int   f, h, p, fr;
        exp_t e;
        f = sb * sl;
        h = f / 2;
        for (int k = 1; k <= nfr * f; k++) begin
            p      = k % f;
            fr     = (k - 1) / f;
            e.gap  = (k == 1) ? 0 : 2 * ((fr == 0) ? d0 : d1);
            e.fs   = (p == 0);
            e.slot = SL_W'(p / sb);
            e.bitn = SB_W'(p % sb);
            if (k == nfr * f) begin
                e.act = 1'b0;
                e.fsy = 1'b0;
            end else begin
                e.act = 1'b1;
                e.fsy = exp_fsync(fmt, p, f, h);
            end
            q.push_back(e);
        end
    endtask

    task automatic wait_pop(input int target, input int budget);
        for (int i = 0; i < budget && n_pop < target; i++) @(negedge clk);
        if (n_pop < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_pop: reached %0d events, want %0d", n_pop, target);
        end
    endtask

    task automatic drain(input string nm, input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s drain: %0d events outstanding, want 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic idle_check(input string nm);
        int bad;
        bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (sclk || active || fsync || bit_strobe || sample_strobe || frame_start) bad++;
        end
        chk({nm, " idle_after_stop"}, bad, 0);
    endtask

    task automatic run_scn(input string nm, input int fmt, input int sb_cfg, input int sl_cfg,
                           input int div_cfg, input int sb, input int sl, input int div,
                           input int nfr, input int stop_at);
        int base;
        cfg_fmt       = 2'(fmt);
        cfg_slot_bits = SB_W'(sb_cfg);
        cfg_slots     = SL_W'(sl_cfg);
        cfg_div       = DIV_W'(div_cfg);
        push_run(fmt, sb, sl, div, div, nfr);
        base = n_pop;
        @(negedge clk);
        en = 1'b1;
        wait_pop(base + stop_at, 20000);
        en = 1'b0;
        drain(nm, 20000);
        idle_check(nm);
    endtask

    initial begin : stim
        int base;
        // Reset holds everything low even with en asserted
        en = 1'b1;
        cfg_div = 8'd4; cfg_slot_bits = 6'd24; cfg_slots = 4'd2; cfg_fmt = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst sclk", int'(sclk), 0);
        chk("rst fsync", int'(fsync), 0);
        chk("rst bit_strobe", int'(bit_strobe), 0);
        chk("rst sample_strobe", int'(sample_strobe), 0);
        chk("rst frame_start", int'(frame_start), 0);
        chk("rst slot_idx", int'(slot_idx), 0);
        chk("rst bit_idx", int'(bit_idx), 0);
        chk("rst active", int'(active), 0);
        en  = 1'b0;
        rst = 1'b1;
        sb_on = 1'b1;
        repeat (2) @(negedge clk);

        // Legacy I2S: 24-bit x 2, div 4; fsync high p 23..46
        run_scn("legacy_i2s", 0, 24, 2, 4, 24, 2, 4, 2, 60);
        // TDM8 DSP: 32-bit x 8, div 1; one-bit pulse at p 255
        run_scn("tdm8_dsp", 2, 32, 8, 1, 32, 8, 1, 2, 300);
        // LJ odd frame 3x16, stop requested in slot 1
        run_scn("lj_odd", 1, 16, 3, 2, 16, 3, 2, 1, 20);
        // Clamping: div 0, slot_bits 1, slots 0 -> div 1, F = 2
        run_scn("clamp", 0, 1, 0, 0, 2, 1, 1, 2, 2);

        // Mid-frame div change only applies after the wrap; brief en drop is cancelled
        cfg_fmt = 2'd0; cfg_slot_bits = 6'd24; cfg_slots = 4'd2; cfg_div = 8'd4;
        push_run(0, 24, 2, 4, 2, 2);
        base = n_pop;
        @(negedge clk);
        en = 1'b1;
        wait_pop(base + 10, 5000);
        cfg_div = 8'd2;
        wait_pop(base + 20, 5000);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        wait_pop(base + 60, 5000);
        en = 1'b0;
        drain("cfg_midframe", 5000);
        idle_check("cfg_midframe");

        // Reset mid-run, then resume from p=0 with en still high
        sb_on = 1'b0;
        cfg_fmt = 2'd0; cfg_slot_bits = 6'd4; cfg_slots = 4'd2; cfg_div = 8'd2;
        @(negedge clk);
        en = 1'b1;
        repeat (37) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst sclk", int'(sclk), 0);
        chk("midrst fsync", int'(fsync), 0);
        chk("midrst active", int'(active), 0);
        chk("midrst pos", int'(slot_idx) + int'(bit_idx), 0);
        q.delete();
        push_run(0, 4, 2, 2, 2, 2);
        base  = n_pop;
        sb_on = 1'b1;
        rst   = 1'b1;
        wait_pop(base + 10, 5000);
        en = 1'b0;
        drain("midrst_resume", 5000);
        idle_check("midrst_resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
